// File: rtl/alu_exec_unit_if.sv
// Operation request and result handshake for the ALU execute unit.
// The master side is upstream plus the result consumer; the slave side is the ALU.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      ALUControl;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ALUResult;
    logic            Zero;
    logic            illegal;

    modport master (
        output in_valid, ALUControl, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, illegal
    );

    modport slave (
        input  in_valid, ALUControl, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execute stage: latency 1 for non-shift ops, 1+shamt for bit-serial shifts.
// A single output slot: new ops are accepted only when idle and the slot is free or being drained.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    alu_exec_unit_if.slave    bus
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1111;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t          r_state;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_work;
    logic [3:0]      r_op;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_illegal;

    logic            w_in_ready;
    logic            w_accept;
    logic [4:0]      w_shamt;
    logic            w_is_shift;
    logic [XLEN-1:0] w_res;
    logic            w_illegal;
    logic [XLEN-1:0] w_step;

    assign w_in_ready = (r_state == IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_shamt    = bus.SrcB[4:0];
    assign w_is_shift = (bus.ALUControl == OP_SLL) || (bus.ALUControl == OP_SRL) ||
                        (bus.ALUControl == OP_SRA);

    // Shifts by zero fall through here and return SrcA with latency 1.
    always_comb begin
        w_res     = '0;
        w_illegal = 1'b0;
        case (bus.ALUControl)
            OP_ADD:  w_res = bus.SrcA + bus.SrcB;
            OP_SUB:  w_res = bus.SrcA - bus.SrcB;
            OP_AND:  w_res = bus.SrcA & bus.SrcB;
            OP_OR:   w_res = bus.SrcA | bus.SrcB;
            OP_XOR:  w_res = bus.SrcA ^ bus.SrcB;
            OP_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
            OP_SLTU: w_res = {{(XLEN-1){1'b0}}, (bus.SrcA < bus.SrcB)};
            OP_SLL, OP_SRL, OP_SRA: w_res = bus.SrcA;
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_step = {1'b0, r_work[XLEN-1:1]};
        case (r_op)
            OP_SLL:  w_step = {r_work[XLEN-2:0], 1'b0};
            OP_SRA:  w_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
            default: w_step = {1'b0, r_work[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_op        <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_shift && (w_shamt != 5'd0)) begin
                            r_work      <= bus.SrcA;
                            r_cnt       <= w_shamt;
                            r_op        <= bus.ALUControl;
                            r_state     <= SHIFT;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_result    <= w_res;
                            r_zero      <= (w_res == '0);
                            r_illegal   <= w_illegal;
                            r_out_valid <= 1'b1;
                        end
                    end else if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    // Output slot is guaranteed empty here: entry required it free.
                    r_work <= w_step;
                    r_cnt  <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_result    <= w_step;
                        r_zero      <= (w_step == '0);
                        r_illegal   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.ALUResult = r_result;
    assign bus.Zero      = r_zero;
    assign bus.illegal   = r_illegal;
endmodule
